// File: rtl/eth_rx_stats.sv
// ---------------------------------------------------------------------------
// eth_rx_stats
//
// Passive receive-side statistics collector for the 1G Ethernet MAC. It
// watches the MAC's rx AXI-Stream output (no tready, every valid beat is
// accepted), classifies each frame on its last beat and keeps frame/byte
// counters. A single-cycle snap_req captures all counters atomically into the
// snap_* registers; snap_clear alongside snap_req zeroes the live counters
// after the capture.
//
// Optional feature: define ETH_STATS_HIST_EN to build a six-bin length
// histogram of good frames. Without it, snap_hist is tied to zero.
//
// Ports:
//   clk                   rx clock (MAC rx_clk)
//   rst_n                 asynchronous active-low reset
//   s_axis_tdata  [7:0]   received byte
//   s_axis_tvalid         byte valid
//   s_axis_tlast          last byte of frame
//   s_axis_tuser          MAC error flag, meaningful on the tlast beat only
//   snap_req              capture counters (one-cycle pulse)
//   snap_clear            with snap_req: zero live counters after capture
//   snap_valid            one-cycle pulse, snap_* outputs freshly loaded
//   snap_good_frames      good frame count
//   snap_good_bytes       bytes of good frames
//   snap_bad_frames       frames flagged bad by the MAC
//   snap_runt_frames      error-free frames shorter than MIN_FRAME_LEN
//   snap_oversize_frames  error-free frames longer than MAX_FRAME_LEN
//   snap_bcast_frames     good frames addressed to FF:FF:FF:FF:FF:FF
//   snap_hist             6 x CNT_W length histogram, bin 0 at the LSBs
// ---------------------------------------------------------------------------
module eth_rx_stats #(
  parameter int CNT_W         = 64,
  parameter int MIN_FRAME_LEN = 60,
  parameter int MAX_FRAME_LEN = 1514
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tuser,
  input  logic               snap_req,
  input  logic               snap_clear,
  output logic               snap_valid,
  output logic [CNT_W-1:0]   snap_good_frames,
  output logic [CNT_W-1:0]   snap_good_bytes,
  output logic [CNT_W-1:0]   snap_bad_frames,
  output logic [CNT_W-1:0]   snap_runt_frames,
  output logic [CNT_W-1:0]   snap_oversize_frames,
  output logic [CNT_W-1:0]   snap_bcast_frames,
  output logic [6*CNT_W-1:0] snap_hist
);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [15:0]      MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0]      MAX_LEN = 16'(MAX_FRAME_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]  state_q;
  logic [15:0] idx_q;
  logic        bcast_q;

  logic [15:0] cur_idx;
  logic [15:0] next_idx;
  logic [15:0] frame_len;
  logic        beat_bcast;
  logic        frame_end;
  logic        is_bad;
  logic        is_runt;
  logic        is_over;
  logic        is_good;
  logic        is_bcast;
  logic        do_clear;

  logic [CNT_W-1:0] good_q,  good_next;
  logic [CNT_W-1:0] bytes_q, bytes_next;
  logic [CNT_W-1:0] bad_q,   bad_next;
  logic [CNT_W-1:0] runt_q,  runt_next;
  logic [CNT_W-1:0] over_q,  over_next;
  logic [CNT_W-1:0] bcast_cnt_q, bcast_next;

  // Per-beat view of the frame. A beat seen in IDLE is always byte 0, so the
  // index and broadcast flag restart there without needing an extra cycle.
  // The broadcast flag survives only while bytes 0..5 are all 0xFF; frames
  // shorter than the 6-byte address are excluded at classification.
  always_comb begin
    cur_idx    = (state_q == ST_IDLE) ? 16'd0 : idx_q;
    next_idx   = (cur_idx == 16'hFFFF) ? 16'hFFFF : cur_idx + 16'd1;
    frame_len  = next_idx;
    beat_bcast = ((state_q == ST_IDLE) ? 1'b1 : bcast_q) &
                 ((cur_idx >= 16'd6) | (s_axis_tdata == 8'hFF));
    frame_end  = s_axis_tvalid & s_axis_tlast & (state_q != ST_SYNC);
    is_bad     = frame_end & s_axis_tuser;
    is_runt    = frame_end & ~s_axis_tuser & (frame_len < MIN_LEN);
    is_over    = frame_end & ~s_axis_tuser & (frame_len >= MIN_LEN) &
                 (frame_len > MAX_LEN);
    is_good    = frame_end & ~s_axis_tuser & (frame_len >= MIN_LEN) &
                 (frame_len <= MAX_LEN);
    is_bcast   = is_good & beat_bcast & (frame_len >= 16'd6);
    do_clear   = snap_req & snap_clear;
  end

  // Frame tracker. SYNC drops everything up to the first tlast so a frame
  // caught halfway after reset is never accounted. Invalid beats are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      idx_q   <= 16'd0;
      bcast_q <= 1'b0;
    end else if (s_axis_tvalid) begin
      case (state_q)
        ST_SYNC: begin
          if (s_axis_tlast) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!s_axis_tlast) begin
            state_q <= ST_ACTIVE;
            idx_q   <= next_idx;
            bcast_q <= beat_bcast;
          end
        end
        ST_ACTIVE: begin
          if (s_axis_tlast) begin
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= next_idx;
            bcast_q <= beat_bcast;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  // Counter next-state values. The snapshot loads these rather than the
  // registered values, so a frame ending in the request cycle is included.
  always_comb begin
    good_next  = good_q + (is_good ? ONE : '0);
    bytes_next = bytes_q + (is_good ? CNT_W'(frame_len) : '0);
    bad_next   = bad_q + (is_bad ? ONE : '0);
    runt_next  = runt_q + (is_runt ? ONE : '0);
    over_next  = over_q + (is_over ? ONE : '0);
    bcast_next = bcast_cnt_q + (is_bcast ? ONE : '0);
  end

  // Live counters and snapshot registers. A clear discards the next-state
  // values only after they have been copied into the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q               <= '0;
      bytes_q              <= '0;
      bad_q                <= '0;
      runt_q               <= '0;
      over_q               <= '0;
      bcast_cnt_q          <= '0;
      snap_valid           <= 1'b0;
      snap_good_frames     <= '0;
      snap_good_bytes      <= '0;
      snap_bad_frames      <= '0;
      snap_runt_frames     <= '0;
      snap_oversize_frames <= '0;
      snap_bcast_frames    <= '0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_good_frames     <= good_next;
        snap_good_bytes      <= bytes_next;
        snap_bad_frames      <= bad_next;
        snap_runt_frames     <= runt_next;
        snap_oversize_frames <= over_next;
        snap_bcast_frames    <= bcast_next;
      end
      if (do_clear) begin
        good_q      <= '0;
        bytes_q     <= '0;
        bad_q       <= '0;
        runt_q      <= '0;
        over_q      <= '0;
        bcast_cnt_q <= '0;
      end else begin
        good_q      <= good_next;
        bytes_q     <= bytes_next;
        bad_q       <= bad_next;
        runt_q      <= runt_next;
        over_q      <= over_next;
        bcast_cnt_q <= bcast_next;
      end
    end
  end

`ifdef ETH_STATS_HIST_EN
  logic [2:0]         hist_bin;
  logic [CNT_W-1:0]   hist_q    [6];
  logic [CNT_W-1:0]   hist_next [6];
  logic [6*CNT_W-1:0] hist_next_flat;

  // Histogram bin selection and next-state values for good frames only.
  always_comb begin
    hist_bin = 3'd5;
    if (frame_len <= 16'd64)        hist_bin = 3'd0;
    else if (frame_len <= 16'd127)  hist_bin = 3'd1;
    else if (frame_len <= 16'd255)  hist_bin = 3'd2;
    else if (frame_len <= 16'd511)  hist_bin = 3'd3;
    else if (frame_len <= 16'd1023) hist_bin = 3'd4;
    hist_next_flat = '0;
    for (int i = 0; i < 6; i++) begin
      hist_next[i] = hist_q[i] + ((is_good && (hist_bin == 3'(i))) ? ONE : '0);
      hist_next_flat[i*CNT_W +: CNT_W] = hist_next[i];
    end
  end

  // Histogram bins follow the same capture-then-clear rule as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) hist_q[i] <= '0;
      snap_hist <= '0;
    end else begin
      if (snap_req) snap_hist <= hist_next_flat;
      for (int i = 0; i < 6; i++) hist_q[i] <= do_clear ? '0 : hist_next[i];
    end
  end
`else
  assign snap_hist = '0;
`endif

endmodule
